// File: rtl/shift_ext_pkg.sv
// Shared definitions for the iterative shift/extend unit.
//   op_e    : 3-bit operation encoding presented on the op port
//   state_e : control FSM states
//   is_shift: true for the three variable-amount shift operations
package shift_ext_pkg;

  typedef enum logic [2:0] {
    OP_SLL    = 3'b000,
    OP_SRL    = 3'b001,
    OP_SRA    = 3'b010,
    OP_SEXT   = 3'b011,
    OP_ZEXT   = 3'b100,
    OP_BR_OFF = 3'b101,
    OP_LUI    = 3'b110,
    OP_ILL    = 3'b111
  } op_e;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'b00,
    ST_SHIFT = 2'b01,
    ST_DONE  = 2'b10
  } state_e;

  function automatic logic is_shift(input op_e o);
    return (o == OP_SLL) || (o == OP_SRL) || (o == OP_SRA);
  endfunction

endpackage

// File: rtl/imm_extender.sv
// Combinational immediate extender.
//   imm_i : IMM_W-bit immediate field
//   op_i  : operation; only SEXT/ZEXT/BR_OFF/LUI produce a non-zero result
//   ext_o : WIDTH-bit extended value (zero for shift and illegal ops)
module imm_extender
  import shift_ext_pkg::*;
#(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned IMM_W = 16
) (
  input  logic [IMM_W-1:0] imm_i,
  input  op_e              op_i,
  output logic [WIDTH-1:0] ext_o
);

  logic [WIDTH-1:0] sext;
  logic [WIDTH-1:0] zext;

  assign sext = {{(WIDTH - IMM_W){imm_i[IMM_W-1]}}, imm_i};
  assign zext = {{(WIDTH - IMM_W){1'b0}}, imm_i};

  always_comb begin
    ext_o = '0;
    case (op_i)
      OP_SEXT:   ext_o = sext;
      OP_ZEXT:   ext_o = zext;
      OP_BR_OFF: ext_o = sext << 2;  // top two bits drop off
      OP_LUI:    ext_o = zext << (WIDTH - IMM_W);
      default:   ext_o = '0;
    endcase
  end

endmodule

// File: rtl/iter_shift_extend.sv
// Multi-cycle shift/extend unit for the EX stage.
// Shifts (SLL/SRL/SRA) advance STEP bits per cycle; extend ops finish in one cycle.
//   clk, rst              : clock, synchronous active-high reset
//   in_valid/in_ready     : request handshake (in_ready only in IDLE and out of reset)
//   op, data_in, imm_in,  : operation and operands, sampled only on accept
//   shamt
//   out_valid/out_ready   : result handshake; result held until out_ready
//   data_out, out_err     : result and illegal-op flag
module iter_shift_extend
  import shift_ext_pkg::*;
#(
  parameter  int unsigned WIDTH   = 32,
  parameter  int unsigned IMM_W   = 16,
  parameter  int unsigned STEP    = 1,
  localparam int unsigned SHAMT_W = $clog2(WIDTH)
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [2:0]         op,
  input  logic [WIDTH-1:0]   data_in,
  input  logic [IMM_W-1:0]   imm_in,
  input  logic [SHAMT_W-1:0] shamt,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [WIDTH-1:0]   data_out,
  output logic               out_err
);

  // One extra bit so STEP == WIDTH is representable.
  localparam int unsigned    CntW    = SHAMT_W + 1;
  localparam logic [CntW-1:0] StepMax = CntW'(STEP);

  state_e               state_q, state_d;
  logic [WIDTH-1:0]     work_q, work_d;
  logic [SHAMT_W-1:0]   rem_q, rem_d;
  op_e                  op_q, op_d;
  logic                 err_q, err_d;

  op_e                  op_in;
  logic                 accept;
  logic [WIDTH-1:0]     ext_val;
  logic [CntW-1:0]      rem_ext;
  logic [CntW-1:0]      step_amt;
  logic [WIDTH-1:0]     shifted;

  assign op_in  = op_e'(op);
  assign accept = in_valid & in_ready;

  imm_extender #(
    .WIDTH (WIDTH),
    .IMM_W (IMM_W)
  ) u_imm_extender (
    .imm_i (imm_in),
    .op_i  (op_in),
    .ext_o (ext_val)
  );

  // State register
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: begin
        if (accept) begin
          state_d = (is_shift(op_in) && (shamt != '0)) ? ST_SHIFT : ST_DONE;
        end
      end
      ST_SHIFT: begin
        if (rem_d == '0) state_d = ST_DONE;
      end
      ST_DONE: begin
        if (out_ready) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Per-step shifter: s = min(STEP, remaining)
  always_comb begin
    rem_ext  = {1'b0, rem_q};
    step_amt = (rem_ext > StepMax) ? StepMax : rem_ext;
    case (op_q)
      OP_SLL:  shifted = work_q << step_amt;
      OP_SRL:  shifted = work_q >> step_amt;
      OP_SRA:  shifted = $unsigned($signed(work_q) >>> step_amt);
      default: shifted = work_q;
    endcase
  end

  // Datapath next-state
  always_comb begin
    work_d = work_q;
    rem_d  = rem_q;
    op_d   = op_q;
    err_d  = err_q;
    case (state_q)
      ST_IDLE: begin
        if (accept) begin
          op_d  = op_in;
          err_d = 1'b0;
          rem_d = '0;
          if (is_shift(op_in)) begin
            // shamt == 0 goes straight to DONE with data_in as the result
            work_d = data_in;
            rem_d  = shamt;
          end else if (op_in == OP_ILL) begin
            work_d = '0;
            err_d  = 1'b1;
          end else begin
            work_d = ext_val;
          end
        end
      end
      ST_SHIFT: begin
        work_d = shifted;
        rem_d  = SHAMT_W'(rem_ext - step_amt);
      end
      ST_DONE: begin
        if (out_ready) err_d = 1'b0;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      work_q <= '0;
      rem_q  <= '0;
      op_q   <= OP_SLL;
      err_q  <= 1'b0;
    end else begin
      work_q <= work_d;
      rem_q  <= rem_d;
      op_q   <= op_d;
      err_q  <= err_d;
    end
  end

  // Outputs
  always_comb begin
    in_ready  = (state_q == ST_IDLE) && !rst;
    out_valid = (state_q == ST_DONE);
    data_out  = work_q;
    out_err   = err_q;
  end

endmodule

// File: tb/tb_iter_shift_extend.sv
// Scoreboard bench: three DUTs (STEP = 4, 1, 32) share the request side; each op's expected
// result and per-instance latency are queued when driven and compared when outputs appear.
module tb_iter_shift_extend;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic        out_ready;
  logic [2:0]  op;
  logic [31:0] data_in;
  logic [15:0] imm_in;
  logic [4:0]  shamt;

  logic [2:0]  in_ready_v;
  logic [2:0]  out_valid_v;
  logic [2:0]  out_err_v;
  logic [31:0] dout [3];

  int n_tests = 0;
  int n_fail  = 0;

  typedef struct {
    logic [31:0]     data;
    logic            err;
    logic [2:0][7:0] lat;
  } exp_t;

  exp_t sb_q[$];

  always #5 clk = ~clk;

  iter_shift_extend #(.WIDTH(32), .IMM_W(16), .STEP(4)) u_dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready_v[0]), .op(op),
    .data_in(data_in), .imm_in(imm_in), .shamt(shamt), .out_valid(out_valid_v[0]),
    .out_ready(out_ready), .data_out(dout[0]), .out_err(out_err_v[0])
  );

  iter_shift_extend #(.WIDTH(32), .IMM_W(16), .STEP(1)) u_dut_s1 (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready_v[1]), .op(op),
    .data_in(data_in), .imm_in(imm_in), .shamt(shamt), .out_valid(out_valid_v[1]),
    .out_ready(out_ready), .data_out(dout[1]), .out_err(out_err_v[1])
  );

  iter_shift_extend #(.WIDTH(32), .IMM_W(16), .STEP(32)) u_dut_s32 (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready_v[2]), .op(op),
    .data_in(data_in), .imm_in(imm_in), .shamt(shamt), .out_valid(out_valid_v[2]),
    .out_ready(out_ready), .data_out(dout[2]), .out_err(out_err_v[2])
  );

  task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  function automatic int step_of(input int i);
    return (i == 0) ? 4 : (i == 1) ? 1 : 32;
  endfunction

  function automatic logic [31:0] ref_result(input logic [2:0] o, input logic [31:0] d,
                                             input logic [15:0] im, input logic [4:0] sh);
    logic [31:0] sx;
    sx = {{16{im[15]}}, im};
    case (o)
      3'd0:    return d << sh;
      3'd1:    return d >> sh;
      3'd2:    return $unsigned($signed(d) >>> sh);
      3'd3:    return sx;
      3'd4:    return {16'h0000, im};
      3'd5:    return sx << 2;
      3'd6:    return {im, 16'h0000};
      default: return 32'h0;
    endcase
  endfunction

  function automatic int ref_lat(input logic [2:0] o, input logic [4:0] sh, input int step);
    if (o <= 3'd2 && sh != 5'd0) return 1 + (int'(sh) + step - 1) / step;
    return 1;
  endfunction

  // Drive one op, collect results from all instances, optionally stall the output 'hold' cycles.
  task automatic run_op(input logic [2:0] o, input logic [31:0] d, input logic [15:0] im,
                        input logic [4:0] sh, input int hold);
    exp_t e;
    exp_t got;
    int   lat [3];
    e.data = ref_result(o, d, im, sh);
    e.err  = (o == 3'b111);
    for (int i = 0; i < 3; i++) e.lat[i] = 8'(ref_lat(o, sh, step_of(i)));
    sb_q.push_back(e);

    @(negedge clk);
    op = o; data_in = d; imm_in = im; shamt = sh; in_valid = 1'b1;
    for (int i = 0; i < 3; i++)
      check_eq($sformatf("in_ready[%0d] before accept", i), 64'(in_ready_v[i]), 64'd1);
    @(posedge clk);
    #1;
    // Scramble operands so late sampling would show up
    in_valid = 1'b0; op = o ^ 3'b101; data_in = ~d; imm_in = ~im; shamt = ~sh;

    for (int i = 0; i < 3; i++) lat[i] = 0;
    for (int c = 1; c <= 60; c++) begin
      @(negedge clk);
      for (int i = 0; i < 3; i++) if (out_valid_v[i] && lat[i] == 0) lat[i] = c;
      if (lat[0] != 0 && lat[1] != 0 && lat[2] != 0) break;
    end

    got = sb_q.pop_front();
    for (int i = 0; i < 3; i++) begin
      check_eq($sformatf("data_out[%0d] op=%0d", i, o), 64'(dout[i]), 64'(got.data));
      check_eq($sformatf("out_err[%0d] op=%0d", i, o), 64'(out_err_v[i]), 64'(got.err));
      check_eq($sformatf("latency[%0d] op=%0d sh=%0d", i, o, sh), 64'(lat[i]), 64'(got.lat[i]));
    end

    for (int h = 0; h < hold; h++) begin
      in_valid = (h % 2 == 0);
      op = 3'd3; imm_in = 16'h5a5a;
      @(negedge clk);
      check_eq("held data_out", 64'(dout[0]), 64'(got.data));
      check_eq("held out_valid", 64'(out_valid_v[0]), 64'd1);
      check_eq("held in_ready", 64'(in_ready_v[0]), 64'd0);
    end
    in_valid = 1'b0;

    out_ready = 1'b1;
    @(posedge clk);
    #1;
    out_ready = 1'b0;
    @(negedge clk);
    check_eq("in_ready after handshake", 64'(in_ready_v), 64'h7);
    check_eq("out_valid after handshake", 64'(out_valid_v), 64'h0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    int stale;
    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0;
    op = '0; data_in = '0; imm_in = '0; shamt = '0;

    repeat (2) @(negedge clk);
    check_eq("in_ready during reset", 64'(in_ready_v), 64'h0);
    @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    check_eq("reset out_valid", 64'(out_valid_v), 64'h0);
    check_eq("reset out_err", 64'(out_err_v), 64'h0);
    check_eq("reset data_out", 64'(dout[0]), 64'h0);
    check_eq("reset in_ready", 64'(in_ready_v), 64'h7);

    // Directed cases
    run_op(3'd2, 32'h8000_0000, 16'h0, 5'd31, 0);   // SRA
    run_op(3'd1, 32'h8000_0000, 16'h0, 5'd31, 0);   // SRL
    run_op(3'd0, 32'h0000_0001, 16'h0, 5'd5, 0);    // SLL
    run_op(3'd0, 32'h0000_0001, 16'h0, 5'd0, 0);    // SLL by 0
    run_op(3'd3, 32'h0, 16'h8000, 5'd0, 0);         // SEXT
    run_op(3'd4, 32'h0, 16'h8000, 5'd0, 0);         // ZEXT
    run_op(3'd5, 32'h0, 16'hFFFF, 5'd0, 0);         // BR_OFF
    run_op(3'd6, 32'h0, 16'h1234, 5'd0, 0);         // LUI
    run_op(3'd7, 32'hDEAD_BEEF, 16'hFFFF, 5'd9, 0); // illegal
    run_op(3'd2, 32'h8765_4321, 16'h0, 5'd7, 5);    // backpressure
    run_op(3'd0, 32'h0000_00FF, 16'h0, 5'd8, 0);    // accepted right after stall

    // Reset mid-shift aborts the op
    @(negedge clk);
    op = 3'd0; data_in = 32'h0000_0001; shamt = 5'd31; in_valid = 1'b1;
    @(posedge clk);
    #1 in_valid = 1'b0;
    repeat (3) @(negedge clk);
    rst = 1'b1;
    #1;
    check_eq("in_ready while rst", 64'(in_ready_v), 64'h0);
    @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    check_eq("abort out_valid", 64'(out_valid_v), 64'h0);
    check_eq("abort data_out0", 64'(dout[0]), 64'h0);
    check_eq("abort data_out1", 64'(dout[1]), 64'h0);
    check_eq("abort data_out2", 64'(dout[2]), 64'h0);
    check_eq("abort in_ready", 64'(in_ready_v), 64'h7);
    stale = 0;
    repeat (40) begin
      @(negedge clk);
      if (out_valid_v != 3'b000) stale = 1;
    end
    check_eq("no stale result", 64'(stale), 64'd0);
    run_op(3'd2, 32'hF000_0000, 16'h0, 5'd4, 0);

    // Random mix
    for (int k = 0; k < 20; k++) begin
      run_op(3'($urandom_range(0, 7)), $urandom, 16'($urandom), 5'($urandom_range(0, 31)),
             (k % 5 == 0) ? 2 : 0);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
